instr_fetch_unit: RTL and testbench

//  Upstream fetch stage for controlunit: owns the program counter, drives the instruction ROM,
//  and buffers returned bytes in a small prefetch FIFO. Presents a valid/ready instruction

---
 rtl/cpu_pkg.sv | 19 +
 rtl/instr_fetch_unit_sync_fifo.sv | 57 +++++
 rtl/instr_fetch_unit.sv | 84 ++++++++
 tb/tb_instr_fetch_unit.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared front-end definitions: default fetch widths, reset PC, fetch FSM states and
// the FIFO entry layout used between fetch and control.
package cpu_pkg;

    localparam int DEF_PC_WIDTH   = 8;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_RESET_PC   = 0;

    typedef enum logic {
        F_RUN,
        F_REDIRECT
    } fetch_state_t;

    typedef struct packed {
        logic [DEF_PC_WIDTH-1:0]   pc;
        logic [DEF_DATA_WIDTH-1:0] data;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_unit_sync_fifo.sv
// Small synchronous FIFO with flush; the head entry is read straight out of the
// storage flops so the consumer sees a registered value.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;

    function automatic logic [AW-1:0] nextPtr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Flush wins over push/pop so a redirect never keeps a stale entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= din;
                wr_ptr_q        <= nextPtr(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= nextPtr(rd_ptr_q);
            end
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the fetch PC, issues ROM reads under a credit limit and buffers
// returned bytes for the control unit; jumps flush everything in flight.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int PC_WIDTH   = DEF_PC_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH = 2,
    parameter int RESET_PC   = DEF_RESET_PC
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  rom_en,
    output logic [PC_WIDTH-1:0]   rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [PC_WIDTH-1:0]   instr_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    input  logic                  jump_en,
    input  logic [PC_WIDTH-1:0]   jump_addr
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t          state_q;
    logic [PC_WIDTH-1:0]   fpc_q;
    logic [PC_WIDTH-1:0]   rom_addr_q;
    logic                  inflight_q;

    logic [CW-1:0]         count;
    logic [CW:0]           credit_used;
    logic                  fifo_valid;
    logic                  pop;
    logic                  push;
    logic                  issue;

    assign fifo_valid  = (count != '0);
    assign pop         = fifo_valid & instr_ready & ~jump_en;
    assign push        = inflight_q & (state_q == F_RUN);
    // Buffered entries plus the read in flight must leave room once this cycle's pop is taken.
    assign credit_used = (CW+1)'(count) + (CW+1)'(inflight_q) - (CW+1)'(pop);
    assign issue       = rst_n & ~jump_en & (credit_used < (CW+1)'(FIFO_DEPTH));

    assign rom_en      = issue;
    assign rom_addr    = fpc_q;
    assign instr_valid = fifo_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= F_RUN;
            fpc_q      <= PC_WIDTH'(RESET_PC);
            rom_addr_q <= PC_WIDTH'(RESET_PC);
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                rom_addr_q <= fpc_q;
                fpc_q      <= fpc_q + 1'b1;
            end
            if (jump_en) begin
                fpc_q   <= jump_addr;
                state_q <= F_REDIRECT;
            end else begin
                state_q <= F_RUN;
            end
        end
    end

    sync_fifo #(
        .WIDTH (PC_WIDTH + DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (jump_en),
        .din   ({rom_addr_q, rom_data}),
        .dout  ({instr_pc, instr}),
        .count (count)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios with literal expectations, then random
// ready/jump/reset traffic, all checked every cycle against a queue-based fetch model.
module tb_instr_fetch_unit;
    import cpu_pkg::*;

    localparam int DEPTH = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rom_en;
    logic [7:0] rom_addr;
    logic [7:0] rom_data = 8'h00;
    logic [7:0] instr;
    logic [7:0] instr_pc;
    logic       instr_valid;
    logic       instr_ready = 1'b1;
    logic       jump_en = 1'b0;
    logic [7:0] jump_addr = 8'h00;

    int vectors = 0;
    int miscompares = 0;

    fetch_entry_t mq[$];
    logic         mPending;
    logic [7:0]   mPaddr;
    logic [7:0]   mFpc;

    instr_fetch_unit #(
        .PC_WIDTH   (8),
        .DATA_WIDTH (8),
        .FIFO_DEPTH (DEPTH),
        .RESET_PC   (0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rom_en      (rom_en),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .jump_en     (jump_en),
        .jump_addr   (jump_addr)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] romByte(input logic [7:0] a);
        return a + 8'h10;
    endfunction

    always @(posedge clk) begin
        if (rom_en) rom_data <= romByte(rom_addr);
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mq.delete();
        mPending = 1'b0;
        mPaddr   = 8'h00;
        mFpc     = 8'h00;
    endtask

    function automatic logic expPop();
        return rst_n && (mq.size() > 0) && instr_ready && !jump_en;
    endfunction

    function automatic logic expRomEn();
        int used;
        used = mq.size() + int'(mPending) - int'(expPop());
        return rst_n && !jump_en && (used < DEPTH);
    endfunction

    // Advance the model across one rising edge using the inputs held during the cycle.
    task automatic modelStep();
        logic issueNow;
        fetch_entry_t e;
        if (!rst_n) return;
        if (jump_en) begin
            mq.delete();
            mPending = 1'b0;
            mFpc     = jump_addr;
            return;
        end
        issueNow = expRomEn();
        if (expPop()) void'(mq.pop_front());
        if (mPending) begin
            e.pc   = mPaddr;
            e.data = romByte(mPaddr);
            mq.push_back(e);
        end
        mPending = issueNow;
        if (issueNow) begin
            mPaddr = mFpc;
            mFpc   = mFpc + 8'h01;
        end
    endtask

    task automatic compareModel();
        checkOutput("rom_en", 32'(rom_en), 32'(expRomEn()));
        checkOutput("rom_addr", 32'(rom_addr), 32'(mFpc));
        checkOutput("instr_valid", 32'(instr_valid), 32'(mq.size() > 0));
        if (!rst_n) begin
            checkOutput("instr_rst", 32'(instr), 32'h0);
            checkOutput("instr_pc_rst", 32'(instr_pc), 32'h0);
        end else if (mq.size() > 0) begin
            checkOutput("instr", 32'(instr), 32'(mq[0].data));
            checkOutput("instr_pc", 32'(instr_pc), 32'(mq[0].pc));
        end
    endtask

    // One cycle: retire the previous cycle into the model, drive new inputs, compare.
    task automatic applyStimulus(input logic rst, input logic rdy, input logic jen, input logic [7:0] jaddr);
        @(posedge clk);
        modelStep();
        @(negedge clk);
        rst_n       = rst;
        instr_ready = rdy;
        jump_en     = jen;
        jump_addr   = jaddr;
        if (!rst) modelReset();
        #1;
        compareModel();
    endtask

    initial begin
        logic [7:0] ja;
        modelReset();

        repeat (3) applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput("lit_reset_rom_en", 32'(rom_en), 32'h0);
        checkOutput("lit_reset_valid", 32'(instr_valid), 32'h0);
        checkOutput("lit_reset_addr", 32'(rom_addr), 32'h0);

        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
        checkOutput("lit_c0_rom_en", 32'(rom_en), 32'h1);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
        checkOutput("lit_c1_valid", 32'(instr_valid), 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
        checkOutput("lit_c2_valid", 32'(instr_valid), 32'h1);
        checkOutput("lit_c2_instr", 32'(instr), 32'h10);
        checkOutput("lit_c2_pc", 32'(instr_pc), 32'h00);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
        checkOutput("lit_c3_instr", 32'(instr), 32'h11);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
        checkOutput("lit_c4_instr", 32'(instr), 32'h12);

        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        checkOutput("lit_hold_rom_en", 32'(rom_en), 32'h0);
        checkOutput("lit_hold_pc", 32'(instr_pc), 32'h03);
        repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
        checkOutput("lit_resume_pc", 32'(instr_pc), 32'h05);
        checkOutput("lit_resume_instr", 32'(instr), 32'h15);

        applyStimulus(1'b1, 1'b1, 1'b1, 8'h40);
        checkOutput("lit_jmp_rom_en", 32'(rom_en), 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
        checkOutput("lit_jmp1_valid", 32'(instr_valid), 32'h0);
        checkOutput("lit_jmp1_addr", 32'(rom_addr), 32'h40);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
        checkOutput("lit_jmp3_pc", 32'(instr_pc), 32'h40);
        checkOutput("lit_jmp3_instr", 32'(instr), 32'h50);

        applyStimulus(1'b1, 1'b1, 1'b1, 8'hFE);
        repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
        checkOutput("lit_wrap_fe", 32'(instr_pc), 32'hFE);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
        checkOutput("lit_wrap_ff", 32'(instr_pc), 32'hFF);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
        checkOutput("lit_wrap_00", 32'(instr_pc), 32'h00);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
        checkOutput("lit_wrap_01", 32'(instr_pc), 32'h01);
        checkOutput("lit_wrap_instr", 32'(instr), 32'h11);

        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput("lit_midrst_rom_en", 32'(rom_en), 32'h0);
        checkOutput("lit_midrst_valid", 32'(instr_valid), 32'h0);
        checkOutput("lit_midrst_instr", 32'(instr), 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
        checkOutput("lit_rerun_pc", 32'(instr_pc), 32'h00);
        checkOutput("lit_rerun_instr", 32'(instr), 32'h10);

        applyStimulus(1'b1, 1'b1, 1'b1, 8'h20);
        applyStimulus(1'b1, 1'b1, 1'b1, 8'h30);
        checkOutput("lit_b2b_rom_en", 32'(rom_en), 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
        checkOutput("lit_b2b_addr", 32'(rom_addr), 32'h30);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
        checkOutput("lit_b2b_valid", 32'(instr_valid), 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
        checkOutput("lit_b2b_pc", 32'(instr_pc), 32'h30);
        checkOutput("lit_b2b_instr", 32'(instr), 32'h40);

        for (int i = 0; i < 1500; i++) begin
            ja = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) ja = mFpc;
            applyStimulus($urandom_range(0, 63) != 0,
                          $urandom_range(0, 3) != 0,
                          $urandom_range(0, 15) == 0,
                          ja);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
